zap_regf_banked: RTL and testbench

ZAP_REGF_BANKED -- requirements
Module: zap_regf_banked

---
 rtl/zap_regf_banked_if.sv | 15 +
 rtl/zap_regf_banked.sv | 193 +++++++++++++++++++
 tb/tb_zap_regf_banked.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_regf_banked_if.sv
// Register-file access bus: packed read indices/data and per-port write controls.
interface zap_regf_banked_if #(
  parameter int IW           = 6,
  parameter int NUM_RD_PORTS = 4,
  parameter int NUM_WR_PORTS = 2
);
  logic [NUM_RD_PORTS*IW-1:0] i_rd_index;
  logic [NUM_RD_PORTS*32-1:0] o_rd_data;
  logic [NUM_WR_PORTS-1:0]    i_wr_en;
  logic [NUM_WR_PORTS*IW-1:0] i_wr_index;
  logic [NUM_WR_PORTS*32-1:0] i_wr_data;

  modport master (output i_rd_index, i_wr_en, i_wr_index, i_wr_data, input o_rd_data);
  modport slave  (input i_rd_index, i_wr_en, i_wr_index, i_wr_data, output o_rd_data);
endinterface

// File: rtl/zap_regf_banked.sv
// Banked ARM-style register file with PC/CPSR, exception entry sequencing and write-to-read bypass.
// Physical map: 0..14 GPRs, 15 PC, 16..20 R14 of FIQ/IRQ/SVC/UND/ABT, 21..25 SPSR in the same order.
module zap_regf_banked #(
  parameter int PHY_REGS     = 46,
  parameter int NUM_RD_PORTS = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter bit BYPASS       = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_clear,
  input  logic [31:0]      i_clear_pc,
  zap_regf_banked_if.slave bus,
  input  logic [31:0]      i_flags,
  input  logic             i_flag_update,
  input  logic [5:0]       i_exc_req,
  input  logic [31:0]      i_vector_base,
  input  logic [31:0]      i_pc_buf,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_cpsr,
  output logic             o_clear,
  output logic [5:0]       o_exc_ack,
  output logic             o_busy
);
  localparam int IW        = $clog2(PHY_REGS);
  localparam int PC_IDX    = 15;
  localparam int R14_BASE  = 16;
  localparam int SPSR_BASE = 21;

  typedef enum logic {RUN, ENTRY} state_t;
  state_t r_state, w_state_next;

  logic [31:0]             w_rf [PHY_REGS];
  logic [31:0]             r_pc, r_cpsr, w_pc_next, w_cpsr_next;
  logic [IW-1:0]           w_wr_idx [NUM_WR_PORTS];
  logic [31:0]             w_wr_dat [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] w_wr_act;
  logic                    w_commit, w_exc, w_pc_wr, w_clear, w_cur_banked;
  logic [31:0]             w_pc_wr_data, w_exc_off, w_lr_data;
  logic [5:0]              w_req, w_ack;
  logic [2:0]              w_exc_bank, w_cur_bank;
  logic [4:0]              w_exc_mode;
  logic [IW-1:0]           w_lr_idx, w_spsr_idx, w_cur_spsr_idx;

  // Masking: fiq by CPSR.F (bit 6), irq by CPSR.I (bit 7).
  assign w_req = i_exc_req & ~{r_cpsr[6], r_cpsr[7], 4'b0000};

  always_comb begin
    w_ack      = 6'b0;
    w_exc_bank = 3'd0;
    w_exc_mode = 5'h00;
    w_exc_off  = 32'h0;
    if (r_state == RUN) begin
      if (w_req[3]) begin
        w_ack = 6'b001000; w_exc_bank = 3'd4; w_exc_mode = 5'h17; w_exc_off = 32'h10;
      end else if (w_req[5]) begin
        w_ack = 6'b100000; w_exc_bank = 3'd0; w_exc_mode = 5'h11; w_exc_off = 32'h1C;
      end else if (w_req[4]) begin
        w_ack = 6'b010000; w_exc_bank = 3'd1; w_exc_mode = 5'h12; w_exc_off = 32'h18;
      end else if (w_req[2]) begin
        w_ack = 6'b000100; w_exc_bank = 3'd4; w_exc_mode = 5'h17; w_exc_off = 32'h0C;
      end else if (w_req[1]) begin
        w_ack = 6'b000010; w_exc_bank = 3'd2; w_exc_mode = 5'h13; w_exc_off = 32'h08;
      end else if (w_req[0]) begin
        w_ack = 6'b000001; w_exc_bank = 3'd3; w_exc_mode = 5'h1B; w_exc_off = 32'h04;
      end
    end
  end

  assign w_exc      = |w_ack;
  assign w_lr_data  = w_ack[3] ? i_pc_buf : i_pc_buf - 32'd4;
  assign w_lr_idx   = IW'(R14_BASE) + IW'(w_exc_bank);
  assign w_spsr_idx = IW'(SPSR_BASE) + IW'(w_exc_bank);
  assign w_commit   = (r_state == RUN) & ~w_exc & i_valid;

  always_comb begin
    w_cur_banked = 1'b1;
    w_cur_bank   = 3'd0;
    case (r_cpsr[4:0])
      5'h11:   w_cur_bank = 3'd0;
      5'h12:   w_cur_bank = 3'd1;
      5'h13:   w_cur_bank = 3'd2;
      5'h1B:   w_cur_bank = 3'd3;
      5'h17:   w_cur_bank = 3'd4;
      default: w_cur_banked = 1'b0;
    endcase
  end
  assign w_cur_spsr_idx = IW'(SPSR_BASE) + IW'(w_cur_bank);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_wr
      assign w_wr_idx[gi] = bus.i_wr_index[gi*IW +: IW];
      assign w_wr_dat[gi] = bus.i_wr_data[gi*32 +: 32];
      assign w_wr_act[gi] = w_commit & bus.i_wr_en[gi] & (int'(w_wr_idx[gi]) < PHY_REGS);
    end
  endgenerate

  always_comb begin
    w_pc_wr      = 1'b0;
    w_pc_wr_data = 32'h0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (w_wr_act[p] && int'(w_wr_idx[p]) == PC_IDX) begin
        w_pc_wr      = 1'b1;
        w_pc_wr_data = w_wr_dat[p];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cpsr_next  = r_cpsr;
    w_clear      = 1'b0;
    case (r_state)
      ENTRY: w_state_next = RUN;
      default: begin
        if (w_exc) begin
          w_state_next = ENTRY;
          w_pc_next    = i_vector_base + w_exc_off;
          w_cpsr_next  = {r_cpsr[31:8], 1'b1, r_cpsr[6] | w_ack[5], 1'b0, w_exc_mode};
          w_clear      = 1'b1;
        end else begin
          if (w_commit)
            w_cpsr_next = (w_pc_wr && i_flag_update && w_cur_banked) ? w_rf[w_cur_spsr_idx] : i_flags;
          if (w_pc_wr) begin
            w_pc_next = w_pc_wr_data;
            w_clear   = 1'b1;
          end else if (i_clear) begin
            w_pc_next = i_clear_pc;
            w_clear   = 1'b1;
          end else if (!i_stall) begin
            w_pc_next = r_pc + (r_cpsr[5] ? 32'd2 : 32'd4);
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= RUN;
      r_pc    <= 32'h0;
      r_cpsr  <= 32'h0000_00D3;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cpsr  <= w_cpsr_next;
    end
  end

  // One register per slot; higher-numbered ports override lower ones on index collisions.
  generate
    for (gi = 0; gi < PHY_REGS; gi++) begin : g_reg
      logic [31:0] r_q, w_d;
      always_comb begin
        w_d = r_q;
        if (w_exc && int'(w_lr_idx) == gi)   w_d = w_lr_data;
        if (w_exc && int'(w_spsr_idx) == gi) w_d = r_cpsr;
        for (int p = 0; p < NUM_WR_PORTS; p++)
          if (w_wr_act[p] && int'(w_wr_idx[p]) == gi) w_d = w_wr_dat[p];
      end
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_q <= 32'h0;
        else            r_q <= w_d;
      end
      assign w_rf[gi] = r_q;
    end

    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [IW-1:0] w_idx;
      logic [31:0]   w_data;
      assign w_idx = bus.i_rd_index[gi*IW +: IW];
      always_comb begin
        if (int'(w_idx) == PC_IDX)       w_data = r_pc;
        else if (int'(w_idx) < PHY_REGS) w_data = w_rf[w_idx];
        else                             w_data = 32'h0;
        if (BYPASS)
          for (int p = 0; p < NUM_WR_PORTS; p++)
            if (w_wr_act[p] && w_wr_idx[p] == w_idx) w_data = w_wr_dat[p];
      end
      assign bus.o_rd_data[gi*32 +: 32] = w_data;
    end
  endgenerate

  assign o_pc      = r_pc;
  assign o_cpsr    = r_cpsr;
  assign o_clear   = i_reset_n & w_clear;
  assign o_exc_ack = w_ack & {6{i_reset_n}};
  assign o_busy    = i_reset_n & (r_state == ENTRY);
endmodule

// File: tb/tb_zap_regf_banked.sv
// Randomized + directed bench; a reference model predicts each cycle, a monitor compares against a queue.
module tb_zap_regf_banked;
  localparam int PHY = 46, NRD = 4, NWR = 2, IW = 6;
  localparam int R14B = 16, SPSRB = 21;

  typedef struct {
    logic [31:0]       pc, cpsr;
    logic              clr, busy;
    logic [5:0]        ack;
    logic [NRD*32-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, stall, clr_in, flag_upd;
  logic [31:0] clear_pc, flags, vbase, pcbuf;
  logic [5:0]  exc_req, pend;
  logic [31:0] o_pc, o_cpsr;
  logic        o_clear, o_busy;
  logic [5:0]  o_ack;

  zap_regf_banked_if #(.IW(IW), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) bus();

  zap_regf_banked #(.PHY_REGS(PHY), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .BYPASS(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_stall(stall), .i_clear(clr_in),
    .i_clear_pc(clear_pc), .bus(bus), .i_flags(flags), .i_flag_update(flag_upd),
    .i_exc_req(exc_req), .i_vector_base(vbase), .i_pc_buf(pcbuf), .o_pc(o_pc),
    .o_cpsr(o_cpsr), .o_clear(o_clear), .o_exc_ack(o_ack), .o_busy(o_busy)
  );

  // Reference model state
  logic [31:0] m_pc, m_cpsr;
  logic [31:0] m_rf [PHY];
  logic        m_entry;
  int          prio [6] = '{3, 5, 4, 2, 1, 0};
  logic [4:0]  legal_modes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};

  exp_t sb_q [$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0, n_txn = 0;

  function automatic int exc_off(int k);
    case (k)
      0: return 4; 1: return 8; 2: return 12; 3: return 16; 4: return 24; default: return 28;
    endcase
  endfunction

  function automatic logic [4:0] exc_mode(int k);
    case (k)
      0: return 5'h1B; 1: return 5'h13; 2: return 5'h17; 3: return 5'h17; 4: return 5'h12;
      default: return 5'h11;
    endcase
  endfunction

  function automatic int bank_of(logic [4:0] m);
    case (m)
      5'h11: return 0; 5'h12: return 1; 5'h13: return 2; 5'h1B: return 3; 5'h17: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s txn=%0d got=%h expected=%h", name, n_txn, act, exp);
    end
  endtask

  task automatic defaults();
    valid = 1'b0; stall = 1'b0; clr_in = 1'b0; clear_pc = 32'h0; flags = 32'h0;
    flag_upd = 1'b0; vbase = 32'h0; pcbuf = 32'h0; exc_req = pend;
    bus.i_wr_en = '0; bus.i_wr_index = '0; bus.i_wr_data = '0;
    bus.i_rd_index = {6'd3, 6'd2, 6'd1, 6'd0};
  endtask

  task automatic wr(int p, int idx, logic [31:0] d);
    bus.i_wr_en[p] = 1'b1;
    bus.i_wr_index[p*IW +: IW] = IW'(idx);
    bus.i_wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(int k, int idx);
    bus.i_rd_index[k*IW +: IW] = IW'(idx);
  endtask

  task automatic req(logic [5:0] bits);
    pend = pend | bits;
    exc_req = pend;
  endtask

  // Predict this cycle's outputs from the inputs now applied, then advance the model past the edge.
  task automatic step();
    exp_t e;
    int taken, ri, wi, b;
    logic commit, pcw;
    logic [31:0] pcw_d, v, newc, inc;
    if (!rst_n) begin
      m_pc = 32'h0; m_cpsr = 32'hD3; m_entry = 1'b0; pend = 6'b0;
      foreach (m_rf[i]) m_rf[i] = 32'h0;
    end
    e.pc = m_pc; e.cpsr = m_cpsr; e.busy = rst_n && m_entry; e.clr = 1'b0; e.ack = 6'b0;
    inc = m_cpsr[5] ? 32'd2 : 32'd4;
    taken = -1;
    if (rst_n && !m_entry)
      foreach (prio[j])
        if (taken < 0 && exc_req[prio[j]] && !(prio[j] == 5 && m_cpsr[6]) && !(prio[j] == 4 && m_cpsr[7]))
          taken = prio[j];
    commit = rst_n && !m_entry && taken < 0 && valid;
    for (int k = 0; k < NRD; k++) begin
      ri = int'(bus.i_rd_index[k*IW +: IW]);
      v = (ri >= PHY) ? 32'h0 : (ri == 15) ? m_pc : m_rf[ri];
      if (commit && ri < PHY)
        for (int p = 0; p < NWR; p++)
          if (bus.i_wr_en[p] && int'(bus.i_wr_index[p*IW +: IW]) == ri) v = bus.i_wr_data[p*32 +: 32];
      e.rd[k*32 +: 32] = v;
    end
    pcw = 1'b0; pcw_d = 32'h0;
    if (commit)
      for (int p = 0; p < NWR; p++)
        if (bus.i_wr_en[p] && int'(bus.i_wr_index[p*IW +: IW]) == 15) begin
          pcw = 1'b1; pcw_d = bus.i_wr_data[p*32 +: 32];
        end
    if (!rst_n) begin
      m_entry = 1'b0;
    end else if (m_entry) begin
      m_entry = 1'b0;
    end else if (taken >= 0) begin
      b = bank_of(exc_mode(taken));
      e.ack = 6'b1 << taken; e.clr = 1'b1;
      m_rf[R14B + b]  = (taken == 3) ? pcbuf : pcbuf - 32'd4;
      m_rf[SPSRB + b] = m_cpsr;
      m_cpsr[4:0] = exc_mode(taken); m_cpsr[5] = 1'b0; m_cpsr[7] = 1'b1;
      if (taken == 5) m_cpsr[6] = 1'b1;
      m_pc = vbase + 32'(exc_off(taken));
      m_entry = 1'b1;
      pend[taken] = 1'b0;
    end else begin
      if (commit) begin
        b = bank_of(m_cpsr[4:0]);
        newc = (pcw && flag_upd && b >= 0) ? m_rf[SPSRB + b] : flags;
        for (int p = 0; p < NWR; p++) begin
          wi = int'(bus.i_wr_index[p*IW +: IW]);
          if (bus.i_wr_en[p] && wi < PHY) m_rf[wi] = bus.i_wr_data[p*32 +: 32];
        end
        m_cpsr = newc;
      end
      if (pcw) begin m_pc = pcw_d; e.clr = 1'b1; end
      else if (clr_in) begin m_pc = clear_pc; e.clr = 1'b1; end
      else if (!stall) m_pc = m_pc + inc;
    end
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    defaults();
  endtask

  // Monitor: samples every cycle away from the rising edge and pops one prediction.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("pc", o_pc, mon_e.pc);
        chk("cpsr", o_cpsr, mon_e.cpsr);
        chk("clear", 32'(o_clear), 32'(mon_e.clr));
        chk("exc_ack", 32'(o_ack), 32'(mon_e.ack));
        chk("busy", 32'(o_busy), 32'(mon_e.busy));
        for (int k = 0; k < NRD; k++)
          chk($sformatf("rd%0d", k), bus.o_rd_data[k*32 +: 32], mon_e.rd[k*32 +: 32]);
        $display("txn %0d: pc=%h cpsr=%h clear=%b ack=%b busy=%b rd0=%h",
                 n_txn, o_pc, o_cpsr, o_clear, o_ack, o_busy, bus.o_rd_data[31:0]);
        n_txn++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; pend = 6'b0;
    defaults();
    repeat (2) begin next_cycle(); step(); end

    // Free-running PC after reset release
    next_cycle(); rst_n = 1'b1; step();
    repeat (3) begin next_cycle(); step(); end

    // Two ports hit index 3: the higher port wins, same cycle and registered
    next_cycle(); valid = 1'b1; flags = 32'hD3;
    wr(0, 3, 32'hAAAA); wr(1, 3, 32'hBBBB); rd(0, 3); step();
    next_cycle(); rd(0, 3); step();

    // USR mode, then irq entry; read banked R14/SPSR during ENTRY
    next_cycle(); valid = 1'b1; flags = 32'h10; step();
    next_cycle(); req(6'b010000); vbase = 32'h0; pcbuf = 32'h108; step();
    next_cycle(); rd(0, R14B + 1); rd(1, SPSRB + 1); step();

    // PC write with S-bit in IRQ mode restores CPSR from SPSR_irq
    next_cycle(); valid = 1'b1; flags = 32'hD3; flag_upd = 1'b1; wr(0, 15, 32'h200); step();
    next_cycle(); step();

    // dabt beats fiq; fiq stays pending and is taken after ENTRY
    next_cycle(); req(6'b101000); vbase = 32'h1000; pcbuf = 32'h300; step();
    next_cycle(); pcbuf = 32'h300; rd(0, R14B + 4); rd(1, SPSRB + 4); step();
    next_cycle(); vbase = 32'h1000; pcbuf = 32'h300; step();
    next_cycle(); rd(0, R14B); rd(1, SPSRB); step();
    next_cycle(); step();

    // Reset asserted mid-ENTRY takes effect without a clock edge
    next_cycle(); req(6'b000010); vbase = 32'h40; pcbuf = 32'h500; step();
    next_cycle(); rst_n = 1'b0; pend = 6'b0; defaults(); step();
    next_cycle(); step();
    next_cycle(); rst_n = 1'b1; step();

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      next_cycle();
      valid    = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      clr_in   = ($urandom_range(0, 7) == 0);
      clear_pc = $urandom & 32'hFFFF_FFFC;
      r        = $urandom;
      flags    = {r[31:5], legal_modes[$urandom_range(0, 6)]};
      flag_upd = ($urandom_range(0, 3) == 0);
      vbase    = $urandom & 32'hFFFF_FFFC;
      pcbuf    = $urandom;
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 1) == 1) wr(p, $urandom_range(0, 50), $urandom);
      for (int k = 0; k < NRD; k++) begin
        if ($urandom_range(0, 1) == 1) rd(k, int'(bus.i_wr_index[$urandom_range(0, NWR-1)*IW +: IW]));
        else rd(k, $urandom_range(0, 50));
      end
      if ($urandom_range(0, 9) == 0) req(6'b1 << $urandom_range(0, 5));
      step();
    end

    repeat (3) @(negedge clk);
    #4;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
